pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It decides each cycle which pipeline registers advance, hold or receive a bubble. Its inputs are load-use hazards, taken branches resolved in EX, multi-cycle instruction and data memory accesses, and halt. It complements the forwarding unit: every hazard that forwarding cannot cover becomes a stall, flush or freeze here.

---
 rtl/pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, imem/dmem waits, halt.
// Optional stall-cycle counter is enabled by defining PIPELINE_HAZARD_CTRL_STATS_EN.
module pipeline_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Rs_if_id,
    input  logic [2:0] Rt_if_id,
    input  logic       Rs_if_id_valid,
    input  logic       Rt_if_id_valid,
    input  logic [2:0] Rd_id_ex,
    input  logic       Rd_id_ex_valid,
    input  logic       MemRead_id_ex,
    input  logic       WriteReg_id_ex,
    input  logic       branch_taken_ex,
    input  logic       imem_busy,
    input  logic       dmem_busy,
    input  logic       halt_mem_wb,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       ex_mem_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       mem_wb_bubble,
    output logic       halted,
    output logic [1:0] state
`ifdef PIPELINE_HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DWAIT      = 2'd1,
        ST_FLUSH_PEND = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   luh_s;

    function automatic logic load_use(
        input logic       mem_read,
        input logic       write_reg,
        input logic [2:0] rd,
        input logic       rd_valid,
        input logic [2:0] rs,
        input logic       rs_valid,
        input logic [2:0] rt,
        input logic       rt_valid
    );
        return mem_read & write_reg & rd_valid &
               ((rs_valid & (rs == rd)) | (rt_valid & (rt == rd)));
    endfunction

    assign luh_s = load_use(MemRead_id_ex, WriteReg_id_ex, Rd_id_ex, Rd_id_ex_valid,
                            Rs_if_id, Rs_if_id_valid, Rt_if_id, Rt_if_id_valid);

    assign state = state_r;

    // State register; reset forces RUN asynchronously, even mid-stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Mealy control decode and next-state selection.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        next_state_s  = state_r;

        case (state_r)
            // DWAIT with memory still busy freezes; once it completes it decides like RUN.
            ST_RUN, ST_DWAIT: begin
                if ((state_r == ST_DWAIT) && dmem_busy) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    next_state_s  = ST_DWAIT;
                end else if (halt_mem_wb) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    id_ex_bubble  = 1'b1;
                    mem_wb_bubble = 1'b1;
                    next_state_s  = ST_HALT;
                end else if (dmem_busy) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    next_state_s  = ST_DWAIT;
                end else if (branch_taken_ex) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (imem_busy) begin
                        next_state_s = ST_FLUSH_PEND;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end else if (luh_s) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    next_state_s = ST_RUN;
                end else if (imem_busy) begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            // The stale fetch issued before the redirect must be squashed when it lands.
            ST_FLUSH_PEND: begin
                pc_write     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (halt_mem_wb) begin
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    next_state_s  = ST_HALT;
                end else if (dmem_busy) begin
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    next_state_s  = ST_FLUSH_PEND;
                end else if (imem_busy) begin
                    next_state_s  = ST_FLUSH_PEND;
                end else begin
                    next_state_s  = ST_RUN;
                end
            end
            ST_HALT: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
                halted        = 1'b1;
                next_state_s  = ST_HALT;
            end
            default: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                mem_wb_bubble = 1'b1;
                next_state_s  = ST_RUN;
            end
        endcase

        // While reset is held the whole pipeline is fed NOPs and nothing advances.
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            halted        = 1'b0;
        end else begin
            halted        = halted;
        end
    end

`ifdef PIPELINE_HAZARD_CTRL_STATS_EN
    logic [15:0] stall_cnt_r;

    assign stall_cycles = stall_cnt_r;

    // Saturating count of cycles the PC was held outside HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (!pc_write && (state_r != ST_HALT) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule
